// File: rtl/stb_pkg.sv
// Shared types for the post-commit store buffer: drain FSM states,
// SRAM-like transfer sizes and the buffered store record.
package stb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } stb_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef struct packed {
    logic [29:0] addr_w;
    logic [31:0] data;
    logic [3:0]  strb;
  } stb_entry_t;

endpackage

// File: rtl/stb_size_enc.sv
// Byte strobe -> SRAM-like transaction(s). Optional feature macro:
// STB_SPLIT3_EN (3-byte strobes become two transactions instead of illegal).
module stb_size_enc
  import stb_pkg::*;
(
  input  logic [3:0] strb,
  output logic       legal,
  output logic       split,
  output logic [1:0] size0,
  output logic [1:0] off0,
  output logic [1:0] size1,
  output logic [1:0] off1
);

  always_comb begin
    legal = 1'b1;
    split = 1'b0;
    size0 = SIZE_BYTE;
    off0  = 2'd0;
    size1 = SIZE_BYTE;
    off1  = 2'd0;
    case (strb)
      4'b0001: off0 = 2'd0;
      4'b0010: off0 = 2'd1;
      4'b0100: off0 = 2'd2;
      4'b1000: off0 = 2'd3;
      4'b0011: size0 = SIZE_HALF;
      4'b1100: begin size0 = SIZE_HALF; off0 = 2'd2; end
      4'b1111: size0 = SIZE_WORD;
`ifdef STB_SPLIT3_EN
      4'b0111: begin
        split = 1'b1;
        size0 = SIZE_HALF; off0 = 2'd0;
        size1 = SIZE_BYTE; off1 = 2'd2;
      end
      4'b1110: begin
        split = 1'b1;
        size0 = SIZE_BYTE; off0 = 2'd1;
        size1 = SIZE_HALF; off1 = 2'd2;
      end
`endif
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// In-order post-commit store queue with one-outstanding SRAM-like drain and
// per-byte load forwarding. Optional feature macro: STB_SPLIT3_EN.
module store_buffer
  import stb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_wdata,
  input  logic [3:0]       st_wstrb,
  input  logic [31:0]      ld_addr,
  output logic [31:0]      fwd_data,
  output logic [3:0]       fwd_we,
  output logic             data_req,
  output logic             data_wr,
  output logic [1:0]       data_size,
  output logic [31:0]      data_addr,
  output logic [31:0]      data_wdata,
  input  logic             data_addr_ok,
  input  logic             data_data_ok,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             err_strb
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  stb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [AW:0] head_q, head_d, tail_q, tail_d, occ;
  stb_state_e  state_q, state_d;
  logic        phase_q, phase_d, err_q, err_d;
  logic        push;

  logic       in_legal, in_split;
  logic [1:0] in_size0, in_off0, in_size1, in_off1;
  stb_entry_t hd;
  logic       hd_legal, hd_split;
  logic [1:0] hd_size0, hd_off0, hd_size1, hd_off1, cur_size, cur_off;

  stb_entry_t  fe;
  logic [AW-1:0] fidx;
  logic        unused_bits;

  stb_size_enc u_push_enc (
    .strb(st_wstrb), .legal(in_legal), .split(in_split),
    .size0(in_size0), .off0(in_off0), .size1(in_size1), .off1(in_off1)
  );

  assign hd = mem_q[head_q[AW-1:0]];

  stb_size_enc u_drain_enc (
    .strb(hd.strb), .legal(hd_legal), .split(hd_split),
    .size0(hd_size0), .off0(hd_off0), .size1(hd_size1), .off1(hd_off1)
  );

  assign unused_bits = ^{in_split, in_size0, in_off0, in_size1, in_off1,
                         hd_legal, st_addr[1:0], ld_addr[1:0]};

  assign occ      = tail_q - head_q;
  assign count    = CNT_W'(occ);
  assign st_ready = (occ != FULL_OCC);
  assign empty    = (occ == '0) && (state_q == S_IDLE);
  assign push     = st_valid && st_ready && in_legal;
  assign err_strb = err_q;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    state_d = state_q;
    phase_d = phase_q;
    err_d   = st_valid && st_ready && !in_legal;
    if (push) begin
      mem_d[tail_q[AW-1:0]] = '{addr_w: st_addr[31:2], data: st_wdata, strb: st_wstrb};
      tail_d = tail_q + PTR_ONE;
    end
    // Next-state looks at tail_d so a push into an idle buffer requests next cycle.
    case (state_q)
      S_IDLE: if (tail_d != head_q) state_d = S_REQ;
      S_REQ:  if (data_addr_ok) state_d = S_WAIT;
      S_WAIT: if (data_data_ok) begin
        if (hd_split && !phase_q) begin
          phase_d = 1'b1;
          state_d = S_REQ;
        end else begin
          phase_d = 1'b0;
          head_d  = head_q + PTR_ONE;
          state_d = (tail_d != head_d) ? S_REQ : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      state_q <= S_IDLE;
      phase_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      state_q <= state_d;
      phase_q <= phase_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  assign cur_size   = phase_q ? hd_size1 : hd_size0;
  assign cur_off    = phase_q ? hd_off1  : hd_off0;
  assign data_req   = (state_q == S_REQ);
  assign data_wr    = data_req;
  assign data_size  = data_req ? cur_size : '0;
  assign data_addr  = data_req ? {hd.addr_w, cur_off} : '0;
  assign data_wdata = data_req ? hd.data : '0;

  // Walk oldest to youngest so younger stores overwrite older lanes.
  always_comb begin
    fwd_we   = '0;
    fwd_data = '0;
    fe       = '0;
    fidx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fidx = head_q[AW-1:0] + AW'(i);
      fe   = mem_q[fidx];
      if (((AW+1)'(i) < occ) && (fe.addr_w == ld_addr[31:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (fe.strb[b]) begin
            fwd_we[b]          = 1'b1;
            fwd_data[8*b +: 8] = fe.data[8*b +: 8];
          end
        end
      end
    end
  end

endmodule
